instruction_prefetch: RTL

INSTRUCTION_PREFETCH -- requirements
Module: instruction_prefetch

---
 rtl/instruction_prefetch.sv | 131 +++++++++++++
 1 files changed

// File: rtl/instruction_prefetch.sv
// In-order instruction prefetch buffer with credit-limited fetch and redirect discard.
// Define FETCH_PERF_CNT_EN to build the delivered-instruction counter on fetch_count.
module instruction_prefetch #(
  parameter int              XLEN     = 32,
  parameter int              AW       = 32,
  parameter int              DEPTH    = 4,
  parameter logic [AW-1:0]   RESET_PC = '0,
  parameter int              PC_STEP  = 4
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [AW-1:0]   imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [AW-1:0]   redirect_pc,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr,
  output logic [AW-1:0]   instr_pc,
  input  logic            instr_ready,
  output logic [31:0]     fetch_count
);

  localparam int            PTR_W = $clog2(DEPTH);
  localparam int            CNT_W = PTR_W + 1;
  localparam int            SUM_W = CNT_W + 2;
  localparam logic [AW-1:0] STEP  = AW'(PC_STEP);

  logic [XLEN-1:0]  data_mem [DEPTH];
  logic [AW-1:0]    pc_mem   [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] occupancy;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] discard;
  logic [AW-1:0]    fetch_pc;
  logic [AW-1:0]    resp_pc;

  logic [SUM_W-1:0] credit_sum;
  logic             accept;
  logic             drop;
  logic             push;
  logic             pop;

  // NOTE: combinational logic uses blocking '=' and gives every output a value on
  // every path, so no latch is inferred; clocked state below uses '<=' only.
  always_comb begin
    credit_sum = SUM_W'(occupancy) + SUM_W'(outstanding) + SUM_W'(discard);
  end

  // Every slot already filled, in flight, or owed to a discard counts against the buffer,
  // so a response can never arrive to a full buffer.
  assign imem_req  = !reset && !redirect_valid && (credit_sum < SUM_W'(DEPTH));
  assign imem_addr = fetch_pc;
  assign accept    = imem_req && imem_ready;

  assign drop = imem_rvalid && (discard != '0);
  assign push = imem_rvalid && (discard == '0) && !redirect_valid && !reset;
  assign pop  = instr_valid && instr_ready && !redirect_valid;

  assign instr_valid = !reset && (occupancy != '0);
  assign instr       = data_mem[rd_ptr];
  assign instr_pc    = pc_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      occupancy   <= '0;
      outstanding <= '0;
      discard     <= '0;
    end else if (redirect_valid) begin
      // Everything still in flight becomes a discard; a response landing now retires one.
      fetch_pc    <= redirect_pc;
      resp_pc     <= redirect_pc;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      occupancy   <= '0;
      outstanding <= '0;
      discard     <= discard + outstanding - CNT_W'(imem_rvalid);
    end else begin
      if (accept) fetch_pc <= fetch_pc + STEP;
      if (push) begin
        wr_ptr  <= wr_ptr + 1'b1;
        resp_pc <= resp_pc + STEP;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   occupancy <= occupancy + 1'b1;
        2'b01:   occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase
      outstanding <= outstanding + CNT_W'(accept) - CNT_W'(push);
      if (drop) discard <= discard - 1'b1;
    end
  end

  // NOTE: the storage arrays are deliberately not reset; occupancy and the pointers
  // alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr] <= imem_rdata;
      pc_mem[wr_ptr]   <= resp_pc;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] pop_count;

  always_ff @(posedge clk) begin
    if (reset)    pop_count <= '0;
    else if (pop) pop_count <= pop_count + 32'd1;
  end

  assign fetch_count = pop_count;
`else
  assign fetch_count = 32'd0;
`endif

  a_push_not_full : assert property (@(posedge clk) disable iff (reset)
    push |-> (occupancy < CNT_W'(DEPTH)));

  a_req_held : assert property (@(posedge clk) disable iff (reset)
    (imem_req && !imem_ready) |=>
      (redirect_valid || (imem_req && (imem_addr == $past(imem_addr)))));

endmodule
